// File: rtl/eer_pkt_pkg.sv
// Shared types and constants for the EER-RL receive packet parser.
package eer_pkt_pkg;

  typedef enum logic [2:0] {
    HB   = 3'b000,
    CHE  = 3'b001,
    INV  = 3'b010,
    MR   = 3'b011,
    CHT  = 3'b100,
    DATA = 3'b101,
    SOS  = 3'b110,
    NONE = 3'b111
  } pkt_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StBody,
    StDrain,
    StPublish,
    StHold
  } parser_state_e;

  localparam int unsigned OFF_SRC      = 1;
  localparam int unsigned OFF_DEST     = 2;
  localparam int unsigned OFF_HOPS     = 3;
  localparam int unsigned OFF_CHOSEN   = 4;
  localparam int unsigned OFF_TIMESLOT = 5;
  localparam int unsigned OFF_ENERGY   = 6;

  localparam logic [15:0] BROADCAST_ID = 16'hFFFF;

  localparam int unsigned HDR_TYPE_MSB = 15;
  localparam int unsigned HDR_TYPE_LSB = 13;
  localparam int unsigned HDR_LEN_MSB  = 12;
  localparam int unsigned HDR_LEN_LSB  = 8;

  // A header is unusable if it cannot hold itself plus one word, overruns the
  // buffer limit, or carries the reserved "none" type.
  function automatic logic headerBad(input logic [2:0] pktType, input logic [4:0] len,
                                     input logic [4:0] maxLen);
    return (len < 5'd2) || (len > maxLen) || (pktType == NONE);
  endfunction

endpackage

// File: rtl/rx_packet_parser_if.sv
// Radio receive word stream: framed 16-bit words with a ready/valid handshake.
interface rx_packet_parser_if #(
  parameter int unsigned WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_sop;
  logic                  rx_eop;
  logic                  rx_ready;

  modport master (
    output rx_data, rx_valid, rx_sop, rx_eop,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_sop, rx_eop,
    output rx_ready
  );
endinterface

// File: rtl/pkt_field_regs.sv
// Shadow field bank filled word by word, copied to a stable output bank on publish.
module pkt_field_regs
  import eer_pkt_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  hdrWe,
  input  logic [2:0]            hdrType,
  input  logic                  wrEn,
  input  logic [2:0]            wrIdx,
  input  logic [WORD_WIDTH-1:0] wrData,
  input  logic                  publish,
  output logic [2:0]            shadowType,
  output logic [WORD_WIDTH-1:0] destView,
  output logic [2:0]            fPacketType,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] destinationID,
  output logic [WORD_WIDTH-1:0] fHopsFromCH,
  output logic [WORD_WIDTH-1:0] fChosenCH,
  output logic [WORD_WIDTH-1:0] fTimeslot,
  output logic [WORD_WIDTH-1:0] fEnergy
);

  logic [2:0]            shType;
  logic [2:0]            outType;
  logic [WORD_WIDTH-1:0] shField  [OFF_SRC:OFF_ENERGY];
  logic [WORD_WIDTH-1:0] pubField [OFF_SRC:OFF_ENERGY];
  logic [WORD_WIDTH-1:0] outField [OFF_SRC:OFF_ENERGY];

  // The final word is written on the same edge as publish, so bypass it.
  always_comb begin
    for (int unsigned k = OFF_SRC; k <= OFF_ENERGY; k++) begin
      pubField[k] = (wrEn && (wrIdx == 3'(k))) ? wrData : shField[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      shType  <= NONE;
      outType <= NONE;
      for (int unsigned k = OFF_SRC; k <= OFF_ENERGY; k++) begin
        shField[k]  <= '1;
        outField[k] <= '1;
      end
    end else begin
      if (hdrWe) begin
        // Fields beyond the packet length must read as all-ones.
        shType <= hdrType;
        for (int unsigned k = OFF_SRC; k <= OFF_ENERGY; k++) begin
          shField[k] <= '1;
        end
      end else if (wrEn) begin
        for (int unsigned k = OFF_SRC; k <= OFF_ENERGY; k++) begin
          if (wrIdx == 3'(k)) begin
            shField[k] <= wrData;
          end
        end
      end
      if (publish) begin
        outType <= shType;
        for (int unsigned k = OFF_SRC; k <= OFF_ENERGY; k++) begin
          outField[k] <= pubField[k];
        end
      end
    end
  end

  assign shadowType    = shType;
  assign destView      = pubField[OFF_DEST];
  assign fPacketType   = outType;
  assign fSourceID     = outField[OFF_SRC];
  assign destinationID = outField[OFF_DEST];
  assign fHopsFromCH   = outField[OFF_HOPS];
  assign fChosenCH     = outField[OFF_CHOSEN];
  assign fTimeslot     = outField[OFF_TIMESLOT];
  assign fEnergy       = outField[OFF_ENERGY];

endmodule

// File: rtl/rx_packet_parser.sv
// Frames the radio word stream into packets and publishes header fields to the controller.
// Optional RX_PKT_FILTER_EN drops CHT/DATA packets addressed to other nodes.
module rx_packet_parser
  import eer_pkt_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  rx_packet_parser_if.slave     rx,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  fields_ack,
  output logic                  pkt_valid,
  output logic [2:0]            fPacketType,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] destinationID,
  output logic [WORD_WIDTH-1:0] fHopsFromCH,
  output logic [WORD_WIDTH-1:0] fChosenCH,
  output logic [WORD_WIDTH-1:0] fTimeslot,
  output logic [WORD_WIDTH-1:0] fEnergy,
  output logic [7:0]            err_count
);

  localparam logic [4:0] MaxLenW      = 5'(MAX_LEN);
  localparam logic [4:0] LastFieldIdx = 5'(OFF_ENERGY);

  parser_state_e stateQ, stateD;
  logic [4:0]    idxQ, idxD;
  logic [4:0]    lenQ, lenD;
  logic          drainHdrQ, drainHdrD;
  logic [7:0]    errCntQ, errCntD;
  logic          rxReadyQ;
  logic          pktValidQ;

  logic            xfer;
  logic [2:0]      hdrType;
  logic [4:0]      hdrLen;
  logic            hdrWe, wrEn, publish;
  logic            abortErr, pktErr;
  logic [1:0]      errInc;
  logic            dropPkt;
  logic [2:0]      shadowType;
  logic [WORD_WIDTH-1:0] destView;

  assign xfer    = rx.rx_valid & rxReadyQ;
  assign hdrType = rx.rx_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
  assign hdrLen  = rx.rx_data[HDR_LEN_MSB:HDR_LEN_LSB];

`ifdef RX_PKT_FILTER_EN
  assign dropPkt = ((shadowType == CHT) || (shadowType == DATA)) &&
                   (destView != myNodeID) && (destView != WORD_WIDTH'(BROADCAST_ID));
`else
  logic unusedFilter;
  assign unusedFilter = ^{myNodeID, destView, shadowType};
  assign dropPkt      = 1'b0;
`endif

  always_comb begin
    stateD    = stateQ;
    idxD      = idxQ;
    lenD      = lenQ;
    drainHdrD = drainHdrQ;
    hdrWe     = 1'b0;
    wrEn      = 1'b0;
    publish   = 1'b0;
    abortErr  = 1'b0;
    pktErr    = 1'b0;
    unique case (stateQ)
      StIdle, StBody, StDrain: begin
        if (xfer && rx.rx_sop) begin
          hdrWe    = 1'b1;
          lenD     = hdrLen;
          idxD     = 5'd1;
          abortErr = (stateQ != StIdle);
          if (rx.rx_eop) begin
            pktErr = 1'b1;
            stateD = StIdle;
          end else if (headerBad(hdrType, hdrLen, MaxLenW)) begin
            // Counted now; the trailing eop in DRAIN must not count again.
            pktErr    = 1'b1;
            drainHdrD = 1'b1;
            stateD    = StDrain;
          end else begin
            stateD = StBody;
          end
        end else if (xfer && (stateQ == StBody)) begin
          wrEn = (idxQ <= LastFieldIdx);
          if (rx.rx_eop) begin
            if (idxQ == lenQ - 5'd1) begin
              if (dropPkt) begin
                stateD = StIdle;
              end else begin
                publish = 1'b1;
                stateD  = StPublish;
              end
            end else begin
              pktErr = 1'b1;
              stateD = StIdle;
            end
          end else if (idxQ == lenQ - 5'd1) begin
            drainHdrD = 1'b0;
            stateD    = StDrain;
          end else begin
            idxD = idxQ + 5'd1;
          end
        end else if (xfer && (stateQ == StDrain) && rx.rx_eop) begin
          pktErr = !drainHdrQ;
          stateD = StIdle;
        end
      end
      StPublish: stateD = fields_ack ? StIdle : StHold;
      StHold: begin
        if (fields_ack) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // An aborting sop that is itself a bad header is two errors in one cycle.
  assign errInc  = {1'b0, abortErr} + {1'b0, pktErr};
  assign errCntD = (errCntQ > (8'd255 - {6'd0, errInc})) ? 8'd255 : errCntQ + {6'd0, errInc};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stateQ    <= StIdle;
      idxQ      <= '0;
      lenQ      <= '0;
      drainHdrQ <= 1'b0;
      errCntQ   <= '0;
      rxReadyQ  <= 1'b0;
      pktValidQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      idxQ      <= idxD;
      lenQ      <= lenD;
      drainHdrQ <= drainHdrD;
      errCntQ   <= errCntD;
      rxReadyQ  <= (stateD == StIdle) || (stateD == StBody) || (stateD == StDrain);
      pktValidQ <= publish;
    end
  end

  pkt_field_regs #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_field_regs (
    .clk          (clk),
    .nrst         (nrst),
    .hdrWe        (hdrWe),
    .hdrType      (hdrType),
    .wrEn         (wrEn),
    .wrIdx        (idxQ[2:0]),
    .wrData       (rx.rx_data),
    .publish      (publish),
    .shadowType   (shadowType),
    .destView     (destView),
    .fPacketType  (fPacketType),
    .fSourceID    (fSourceID),
    .destinationID(destinationID),
    .fHopsFromCH  (fHopsFromCH),
    .fChosenCH    (fChosenCH),
    .fTimeslot    (fTimeslot),
    .fEnergy      (fEnergy)
  );

  assign rx.rx_ready = rxReadyQ;
  assign pkt_valid   = pktValidQ;
  assign err_count   = errCntQ;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Scoreboard bench for rx_packet_parser: directed packets, publish monitor, error-count checks.
module tb_rx_packet_parser;
  import eer_pkt_pkg::*;

  typedef struct packed {
    logic [2:0]  t;
    logic [15:0] src, dst, hops, ch, ts, en;
  } fields_t;
  typedef logic [15:0] word_q_t [$];

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] myNodeID;
  logic        fields_ack;
  logic        pkt_valid;
  logic [2:0]  fPacketType;
  logic [15:0] fSourceID, destinationID, fHopsFromCH, fChosenCH, fTimeslot, fEnergy;
  logic [7:0]  err_count;

  int      vectors = 0;
  int      miscompares = 0;
  fields_t expQ [$];
  fields_t lastPub;
  word_q_t pkt;

  always #5 clk = ~clk;

  rx_packet_parser_if #(.WORD_WIDTH(16)) rxIf ();

  rx_packet_parser #(
    .WORD_WIDTH(16),
    .MAX_LEN   (16)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .rx           (rxIf.slave),
    .myNodeID     (myNodeID),
    .fields_ack   (fields_ack),
    .pkt_valid    (pkt_valid),
    .fPacketType  (fPacketType),
    .fSourceID    (fSourceID),
    .destinationID(destinationID),
    .fHopsFromCH  (fHopsFromCH),
    .fChosenCH    (fChosenCH),
    .fTimeslot    (fTimeslot),
    .fEnergy      (fEnergy),
    .err_count    (err_count)
  );

  function automatic fields_t mk(input logic [2:0] t, input logic [15:0] src, dst, hops, ch,
                                 ts, en);
    return {t, src, dst, hops, ch, ts, en};
  endfunction

  function automatic fields_t actual();
    return {fPacketType, fSourceID, destinationID, fHopsFromCH, fChosenCH, fTimeslot, fEnergy};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Publish monitor: every pkt_valid pulse must match the oldest expected bank.
  always @(negedge clk) begin
    if (nrst === 1'b1 && pkt_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_publish: got bank %0h, expected no publish", actual());
      end else begin
        lastPub = expQ.pop_front();
        check("publish_fields", 128'(actual()), 128'(lastPub));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic sendWord(input logic [15:0] d, input logic sop, input logic eop);
    int waited = 0;
    rxIf.rx_data  = d;
    rxIf.rx_valid = 1'b1;
    rxIf.rx_sop   = sop;
    rxIf.rx_eop   = eop;
    while (rxIf.rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: rx_ready=%b after %0d cycles, expected 1", rxIf.rx_ready,
               waited);
    end
    @(negedge clk);
    rxIf.rx_valid = 1'b0;
    rxIf.rx_sop   = 1'b0;
    rxIf.rx_eop   = 1'b0;
  endtask

  task automatic sendPkt(input word_q_t w);
    for (int i = 0; i < w.size(); i++) begin
      sendWord(w[i], i == 0, i == w.size() - 1);
    end
  endtask

  task automatic ackFields();
    fields_ack = 1'b1;
    @(negedge clk);
    fields_ack = 1'b0;
  endtask

  initial begin
    nrst          = 1'b0;
    fields_ack    = 1'b0;
    myNodeID      = 16'd12;
    rxIf.rx_data  = '0;
    rxIf.rx_valid = 1'b0;
    rxIf.rx_sop   = 1'b0;
    rxIf.rx_eop   = 1'b0;
    lastPub       = mk(3'b111, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Reset held across two edges.
    repeat (2) @(negedge clk);
    check("reset_type", 128'(fPacketType), 128'(3'b111));
    check("reset_fields", 128'(actual()), 128'(lastPub));
    check("reset_err", 128'(err_count), 128'(0));
    check("reset_pkt_valid", 128'(pkt_valid), 128'(0));
    check("reset_ready", 128'(rxIf.rx_ready), 128'(0));
    nrst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(rxIf.rx_ready), 128'(1));

    // INV, L=7: pulse right after eop, ready held low until ack.
    pkt = '{16'h4700, 16'd5, 16'hFFFF, 16'd1, 16'd23, 16'd0, 16'd900};
    expQ.push_back(mk(3'b010, 16'd5, 16'hFFFF, 16'd1, 16'd23, 16'd0, 16'd900));
    sendPkt(pkt);
    check("inv_pulse", 128'(pkt_valid), 128'(1));
    check("inv_ready_low", 128'(rxIf.rx_ready), 128'(0));
    @(negedge clk);
    check("inv_pulse_width", 128'(pkt_valid), 128'(0));
    repeat (3) @(negedge clk);
    check("hold_ready_low", 128'(rxIf.rx_ready), 128'(0));
    check("inv_energy", 128'(fEnergy), 128'(900));
    ackFields();
    check("ack_ready", 128'(rxIf.rx_ready), 128'(1));

    // HB, L=3, ack given during the publish cycle.
    pkt = '{16'h0300, 16'd7, 16'hFFFF};
    expQ.push_back(mk(3'b000, 16'd7, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    sendPkt(pkt);
    ackFields();
    check("ack_in_publish_ready", 128'(rxIf.rx_ready), 128'(1));
    check("hb_timeslot", 128'(fTimeslot), 128'(16'hFFFF));

    // L=5 but eop on w2.
    pkt = '{16'h4500, 16'd11, 16'd22};
    sendPkt(pkt);
    check("short_no_pulse", 128'(pkt_valid), 128'(0));
    check("short_err", 128'(err_count), 128'(1));
    check("short_outputs_hold", 128'(actual()), 128'(lastPub));

    // sop mid-packet aborts, the new MR packet parses.
    sendWord(16'h4500, 1'b1, 1'b0);
    sendWord(16'd1, 1'b0, 1'b0);
    pkt = '{16'h6400, 16'h0055, 16'd9, 16'd3};
    expQ.push_back(mk(3'b011, 16'h0055, 16'd9, 16'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    sendPkt(pkt);
    check("abort_err", 128'(err_count), 128'(2));
    ackFields();

    // CHT to another node.
    pkt = '{16'h8700, 16'd2, 16'd3, 16'd1, 16'd2, 16'd4, 16'd50};
`ifdef RX_PKT_FILTER_EN
    sendPkt(pkt);
    check("filter_drop_no_pulse", 128'(pkt_valid), 128'(0));
    check("filter_drop_ready", 128'(rxIf.rx_ready), 128'(1));
`else
    expQ.push_back(mk(3'b100, 16'd2, 16'd3, 16'd1, 16'd2, 16'd4, 16'd50));
    sendPkt(pkt);
    check("nofilter_pulse", 128'(pkt_valid), 128'(1));
    ackFields();
`endif
    check("filter_err_unchanged", 128'(err_count), 128'(2));

    // CHT to this node, then DATA broadcast: both publish in every build.
    pkt = '{16'h8700, 16'd2, 16'd12, 16'd1, 16'd2, 16'd4, 16'd50};
    expQ.push_back(mk(3'b100, 16'd2, 16'd12, 16'd1, 16'd2, 16'd4, 16'd50));
    sendPkt(pkt);
    ackFields();
    check("cht_timeslot", 128'(fTimeslot), 128'(4));
    pkt = '{16'hA300, 16'h0021, 16'hFFFF};
    expQ.push_back(mk(3'b101, 16'h0021, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    sendPkt(pkt);
    ackFields();

    // Reserved type, overlong body, stray word, L over MAX_LEN.
    pkt = '{16'hE300, 16'd1, 16'd2};
    sendPkt(pkt);
    check("type111_err", 128'(err_count), 128'(3));
    pkt = '{16'h2300, 16'd1, 16'd2, 16'd3, 16'd4};
    sendPkt(pkt);
    check("long_err", 128'(err_count), 128'(4));
    sendWord(16'h1234, 1'b0, 1'b0);
    check("stray_no_err", 128'(err_count), 128'(4));
    pkt = '{16'h1100, 16'd1};
    sendPkt(pkt);
    check("maxlen_err", 128'(err_count), 128'(5));
    check("bad_outputs_hold", 128'(actual()), 128'(lastPub));

    // Reset mid-packet.
    sendWord(16'h4700, 1'b1, 1'b0);
    sendWord(16'd5, 1'b0, 1'b0);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    lastPub = mk(3'b111, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    check("midreset_err", 128'(err_count), 128'(0));
    check("midreset_fields", 128'(actual()), 128'(lastPub));
    pkt = '{16'h0300, 16'd7, 16'hFFFF};
    expQ.push_back(mk(3'b000, 16'd7, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    sendPkt(pkt);
    ackFields();
    check("post_reset_err", 128'(err_count), 128'(0));

    // One-word packets until the counter saturates.
    repeat (254) sendWord(16'h2100, 1'b1, 1'b1);
    check("err_254", 128'(err_count), 128'(254));
    repeat (46) sendWord(16'h2100, 1'b1, 1'b1);
    check("err_saturated", 128'(err_count), 128'(255));
    check("sat_outputs_hold", 128'(actual()), 128'(lastPub));

    repeat (3) @(negedge clk);
    check("queue_drained", 128'(expQ.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
